// File: rtl/lsu_subword_if.sv
// CPU request/response and word-memory bus bundle for lsu_subword.
// master = CPU + data memory side, slave = lsu_subword.
interface lsu_subword_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dm_addr;
    logic        dm_we;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    modport master (
        output req_valid, req_we, req_size, req_sign,
        output req_addr, req_wdata, req_pc, dm_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  dm_addr, dm_we, dm_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_sign,
        input  req_addr, req_wdata, req_pc, dm_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output dm_addr, dm_we, dm_wdata
    );
endinterface

// File: rtl/lsu_subword.sv
// Sub-word load/store unit over a word-only data memory (RMW for sb/sh).
// Optional STORE_TRACE_EN macro prints every committed DM write.
module lsu_subword #(
    parameter bit TRAP_MISALIGNED = 1'b1
) (
    input logic         clk,
    input logic         reset,
    lsu_subword_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] WR   = 3'd2;
    localparam logic [2:0] RESP = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    logic [2:0]  state;
    logic        we_q;
    logic        sign_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic [31:0] rbuf;

    logic        accept;
    logic        in_word;
    logic        in_half;
    logic        misal;
    logic [31:0] addr_al;
    logic        q_byte;
    logic        q_half;
    logic [7:0]  lane8;
    logic [15:0] lane16;
    logic [31:0] merged;
    logic [31:0] ext;

    assign accept  = bus.req_valid && (state == IDLE);
    assign in_word = bus.req_size[1];
    assign in_half = (bus.req_size == 2'b01);
    assign misal   = (in_half && bus.req_addr[0]) ||
                     (in_word && (bus.req_addr[1:0] != 2'b00));

    // Natural alignment of the incoming address (used when not trapping)
    always_comb begin
        addr_al = bus.req_addr;
        if (in_half) addr_al[0] = 1'b0;
        if (in_word) addr_al[1:0] = 2'b00;
    end

    // Request latch, read buffer and control FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            pc_q    <= 32'd0;
            rbuf    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= bus.req_we;
                        sign_q  <= bus.req_sign;
                        size_q  <= bus.req_size;
                        addr_q  <= addr_al;
                        wdata_q <= bus.req_wdata;
                        pc_q    <= bus.req_pc;
                        if (misal && TRAP_MISALIGNED)
                            state <= ERR;
                        else if (bus.req_we && in_word)
                            state <= WR;
                        else
                            state <= RD;
                    end
                end
                RD: begin
                    rbuf  <= bus.dm_rdata;
                    state <= we_q ? WR : RESP;
                end
                WR:      state <= RESP;
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign q_byte = (size_q == 2'b00);
    assign q_half = (size_q == 2'b01);
    assign lane8  = rbuf[{addr_q[1:0], 3'b000} +: 8];
    assign lane16 = rbuf[{addr_q[1], 4'b0000} +: 16];

    // Store word: target lane of rbuf replaced, or the full store word
    always_comb begin
        merged = rbuf;
        unique case (1'b1)
            q_byte:  merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            q_half:  merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Load data: lane extraction with sign or zero extension
    always_comb begin
        ext = rbuf;
        unique case (1'b1)
            q_byte:  ext = {{24{sign_q & lane8[7]}}, lane8};
            q_half:  ext = {{16{sign_q & lane16[15]}}, lane16};
            default: ext = rbuf;
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.dm_addr    = {addr_q[31:2], 2'b00};
    assign bus.dm_we      = (state == WR);
    assign bus.dm_wdata   = (state == WR) ? merged : 32'd0;
    assign bus.resp_valid = (state == RESP) || (state == ERR);
    assign bus.resp_err   = (state == ERR);
    assign bus.resp_rdata = (state == RESP && !we_q) ? ext : 32'd0;

`ifdef STORE_TRACE_EN
    // Trace each committed DM write with the full merged word
    always @(posedge clk) begin
        if (reset && state == WR)
            $display("@%h: *%h <= %h", pc_q, bus.dm_addr, bus.dm_wdata);
    end
`endif
endmodule

// File: tb/tb_lsu_subword.sv
// Bench for lsu_subword: trapping and aligning instances side by side,
// each against its own word memory and a byte-lane reference model.
module tb_lsu_subword;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lsu_subword_if b0();
    lsu_subword_if b1();

    lsu_subword #(.TRAP_MISALIGNED(1'b1)) u0 (
        .clk(clk), .reset(reset), .bus(b0)
    );
    lsu_subword #(.TRAP_MISALIGNED(1'b0)) u1 (
        .clk(clk), .reset(reset), .bus(b1)
    );

    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];
    logic [31:0] rm0 [64];
    logic [31:0] rm1 [64];
    logic        poke_en = 1'b0;
    logic [5:0]  poke_idx = 6'd0;
    logic [31:0] poke_val = 32'd0;

    assign b0.dm_rdata = mem0[b0.dm_addr[7:2]];
    assign b1.dm_rdata = mem1[b1.dm_addr[7:2]];

    // Data memories: DUT writes, or bench pokes when the DUT is quiet
    always @(posedge clk) begin
        if (b0.dm_we) mem0[b0.dm_addr[7:2]] <= b0.dm_wdata;
        else if (poke_en) mem0[poke_idx] <= poke_val;
        if (b1.dm_we) mem1[b1.dm_addr[7:2]] <= b1.dm_wdata;
        else if (poke_en) mem1[poke_idx] <= poke_val;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_misal(input logic [1:0] sz, input logic [31:0] a);
        int n;
        n = nbytes(sz);
        return (a % n) != 0;
    endfunction

    function automatic logic [31:0] ld_model(input logic [31:0] w, input int off,
                                             input int n, input bit sgn);
        logic [31:0] v;
        if (n == 4) return w;
        v = (w >> (8 * off)) & ((32'd1 << (8 * n)) - 32'd1);
        if (sgn && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] st_model(input logic [31:0] w, input int off,
                                             input int n, input logic [31:0] d);
        logic [31:0] m;
        if (n == 4) m = 32'hFFFF_FFFF;
        else m = ((32'd1 << (8 * n)) - 32'd1) << (8 * off);
        return (w & ~m) | ((d << (8 * off)) & m);
    endfunction

    task automatic poke(input int idx, input logic [31:0] v);
        @(negedge clk);
        poke_en = 1'b1;
        poke_idx = idx[5:0];
        poke_val = v;
        rm0[idx] = v;
        rm1[idx] = v;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] pc);
        b0.req_valid = 1'b1; b1.req_valid = 1'b1;
        b0.req_we = we;      b1.req_we = we;
        b0.req_size = sz;    b1.req_size = sz;
        b0.req_sign = sg;    b1.req_sign = sg;
        b0.req_addr = a;     b1.req_addr = a;
        b0.req_wdata = wd;   b1.req_wdata = wd;
        b0.req_pc = pc;      b1.req_pc = pc;
    endtask

    logic [31:0] rd0, rd1, wa0;
    logic        er0, er1;
    int          lat0, lat1, wc0, wc1;

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] pc);
        int n, idx, off, xl;
        bit m;
        logic [31:0] aa, x0, x1;
        n = nbytes(sz);
        m = is_misal(sz, a);
        aa = a & ~(n - 1);
        idx = int'(aa[7:2]);
        off = int'(aa[1:0]);
        @(negedge clk);
        check("ready_idle", {31'd0, b0.req_ready}, 32'd1);
        drive(we, sz, sg, a, wd, pc);
        @(negedge clk);
        b0.req_valid = 1'b0;
        b1.req_valid = 1'b0;
        lat0 = 0; lat1 = 0; wc0 = 0; wc1 = 0;
        rd0 = 32'hx; rd1 = 32'hx; er0 = 1'bx; er1 = 1'bx; wa0 = 32'hx;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            if (b0.dm_we) begin wc0++; wa0 = b0.dm_addr; end
            if (b1.dm_we) wc1++;
            if (lat0 == 0 && b0.resp_valid) begin
                lat0 = k; rd0 = b0.resp_rdata; er0 = b0.resp_err;
            end
            if (lat1 == 0 && b1.resp_valid) begin
                lat1 = k; rd1 = b1.resp_rdata; er1 = b1.resp_err;
            end
        end
        xl = !we ? 2 : (n == 4) ? 2 : 3;
        x1 = we ? 32'd0 : ld_model(rm1[idx], off, n, sg);
        if (we) rm1[idx] = st_model(rm1[idx], off, n, wd);
        if (m) begin
            check("t_lat", lat0, 1);
            check("t_err", {31'd0, er0}, 32'd1);
            check("t_rdata", rd0, 32'd0);
            check("t_wecnt", wc0, 0);
        end else begin
            x0 = we ? 32'd0 : ld_model(rm0[idx], off, n, sg);
            if (we) rm0[idx] = st_model(rm0[idx], off, n, wd);
            check("t_lat", lat0, xl);
            check("t_err", {31'd0, er0}, 32'd0);
            check("t_rdata", rd0, x0);
            check("t_wecnt", wc0, we ? 1 : 0);
        end
        check("t_mem", mem0[idx], rm0[idx]);
        check("a_lat", lat1, xl);
        check("a_err", {31'd0, er1}, 32'd0);
        check("a_rdata", rd1, x1);
        check("a_wecnt", wc1, we ? 1 : 0);
        check("a_mem", mem1[idx], rm1[idx]);
    endtask

    initial begin
        drive(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0);
        b0.req_valid = 1'b0;
        b1.req_valid = 1'b0;
        #2;
        check("rst_resp_valid", {31'd0, b0.resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, b0.resp_err}, 32'd0);
        check("rst_rdata", b0.resp_rdata, 32'd0);
        check("rst_dm_we", {31'd0, b0.dm_we}, 32'd0);
        check("rst_dm_addr", b0.dm_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 check("rst_ready", {31'd0, b0.req_ready}, 32'd1);

        for (int i = 0; i < 64; i++) poke(i, $urandom);
        poke(4, 32'h8899_AABB);

        do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'd0, 32'h1000);
        check("lb_s", rd0, 32'hFFFF_FF99);
        do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'd0, 32'h1004);
        check("lbu", rd0, 32'h0000_0099);
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 32'h1008);
        check("lh_s", rd0, 32'hFFFF_AABB);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 32'h100C);
        check("lhu", rd0, 32'h0000_8899);

        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_56CC, 32'h2000);
        check("sb_mem", mem0[4], 32'h8899_CCBB);
        check("sb_lat", lat0, 3);
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF, 32'h2004);
        check("sh_mem", mem0[4], 32'hBEEF_CCBB);

        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h3000);
        check("sw_mem", mem0[8], 32'hDEAD_BEEF);
        check("sw_addr", wa0, 32'h20);
        check("sw_lat", lat0, 2);

        do_req(1'b0, 2'b01, 1'b1, 32'h13, 32'd0, 32'h4000);
        check("mis_lh_err", {31'd0, er0}, 32'd1);
        check("mis_lh_al", rd1, 32'hFFFF_BEEF);
        do_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h5555_AAAA, 32'h4004);
        check("mis_sw_err", {31'd0, er0}, 32'd1);
        check("mis_sw_keep", mem0[8], 32'hDEAD_BEEF);

        // Reset in the WR cycle of a byte store aborts the write
        poke(4, 32'h8899_AABB);
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_56CC, 32'h5000);
        @(negedge clk);
        b0.req_valid = 1'b0;
        b1.req_valid = 1'b0;
        check("abort_rd_we", {31'd0, b0.dm_we}, 32'd0);
        @(negedge clk);
        check("abort_wr_we", {31'd0, b0.dm_we}, 32'd1);
        #1 reset = 1'b0;
        #1 check("abort_we_fall", {31'd0, b0.dm_we}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 check("abort_ready", {31'd0, b0.req_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_no_resp", {31'd0, b0.resp_valid}, 32'd0);
        end
        check("abort_mem0", mem0[4], 32'h8899_AABB);
        check("abort_mem1", mem1[4], 32'h8899_AABB);

        // Request held valid across two loads
        @(negedge clk);
        drive(1'b0, 2'b00, 1'b0, 32'h12, 32'd0, 32'h6000);
        @(negedge clk);
        drive(1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 32'h6004);
        check("b2b_busy1", {31'd0, b0.req_ready}, 32'd0);
        @(negedge clk);
        check("b2b_busy2", {31'd0, b0.req_ready}, 32'd0);
        check("b2b_resp1_v", {31'd0, b0.resp_valid}, 32'd1);
        check("b2b_resp1_d", b0.resp_rdata, 32'h0000_0099);
        @(negedge clk);
        check("b2b_idle", {31'd0, b0.req_ready}, 32'd1);
        check("b2b_idle_nv", {31'd0, b0.resp_valid}, 32'd0);
        @(negedge clk);
        b0.req_valid = 1'b0;
        b1.req_valid = 1'b0;
        check("b2b_busy3", {31'd0, b0.req_ready}, 32'd0);
        @(negedge clk);
        check("b2b_resp2_v", {31'd0, b0.resp_valid}, 32'd1);
        check("b2b_resp2_d", b0.resp_rdata, 32'hFFFF_AABB);

        for (int i = 0; i < 40; i++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                   $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
